pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Occupancy/handshake sequencer for a chain of NUM_STG single-entry stage registers (PC->IF->ID->EXE->MEM->WB).
//  Tracks per-register occupancy, drives each register's write/read strobes, and propagates stalls backward.
//  Kills younger registers on a redirect flush; sequences halt via drain.
//  One instance per CPU, beside the stage registers.
// PARAMETERS
//  NUM_STG    5  number of stage registers; reg i feeds stage i+1
//  FLUSH_CYC  2  refetch bubble cycles after a flush; range 1..15
//  CNT_W      32 width of perf counters (PIPE_CTRL_PERF_EN only)
// PORTS
//  clk_in        in   1        clock, rising edge
//  reset_in      in   1        synchronous, active-high reset
//  src_vld_in    in   1        fetch has an item for reg 0
//  src_rdy_out   out  1        reg 0 accepts this cycle
//  stall_in      in   NUM_STG  stall_in[i]: stage consuming reg i is busy
//  dst_rdy_in    in   1        retire side accepts reg NUM_STG-1
//  dst_vld_out   out  1        reg NUM_STG-1 is offered to retire
//  flush_in      in   1        redirect request
//  flush_idx_in  in   $clog2(NUM_STG)  kill regs 0..flush_idx_in (younger)
//  halt_in       in   1        level; request quiesce
//  halted_out    out  1        pipeline empty and halted
//  wr_out        out  NUM_STG  write strobe to each register
//  rd_out        out  NUM_STG  read strobe to each register
//  kill_out      out  NUM_STG  register content discarded this cycle
//  vld_out       out  NUM_STG  occupancy vector occ[]
// BEHAVIOUR
//  - Reset: occ=0, state=RUN, flush counter 0; all outputs 0 while reset_in=1. This includes src_rdy_out, wr_out and halted_out.
//  - adv[i] = occ[i] & !stall_in[i] & (i==NUM_STG-1 ? dst_rdy_in : acc[i+1]).
//  - acc[i] = !occ[i] | adv[i]; acc ripples combinationally from the last register back.
//  - rd_out[i]=adv[i]; wr_out[i]=adv[i-1] for i>0.
//  - wr_out[0]=src_vld_in & acc[0] & state==RUN & !flush_in & !halt_in.
//  - src_rdy_out = acc[0] & state==RUN & !flush_in & !halt_in.
//  - dst_vld_out = occ[NUM_STG-1] & !stall_in[NUM_STG-1].
//  - occ[i] next = wr_out[i] | (occ[i] & !rd_out[i]). Zero-latency pass-through is not allowed: one register = one cycle.
//  - Flush cycle (flush_in=1):
//    - kill_out[j]=occ[j] for j<=idx; adv[j] forced 0 for j<=idx; wr_out[0]=0.
//    - occ[j] for j<=idx clears next cycle. Regs >idx advance normally.
//  - FSM states RUN, FLUSH, DRAIN, HALTED:
//    - RUN -flush_in-> FLUSH (counter=FLUSH_CYC-1). Flush beats halt.
//    - RUN -halt_in-> DRAIN.
//    - FLUSH: counts down; at 0 -> RUN (or DRAIN if halt_in). A new flush_in reloads the counter and kills again.
//    - DRAIN: no new input; -> HALTED when occ==0 (same-cycle check on next-state occ).
//    - DRAIN -flush_in-> kill applies, stays DRAIN.
//    - HALTED: halted_out=1; -!halt_in-> RUN.
//  - Simultaneous adv and flush on the same register: kill wins, no rd_out.
//  - All-stall with full pipe: no strobes, occ unchanged indefinitely.
// CONFIGURATION
//  - PIPE_CTRL_PERF_EN defined: adds outputs stall_cnt_out[CNT_W] and flush_cnt_out[CNT_W].
//    - stall_cnt_out: cycles with src_vld_in & !src_rdy_out in RUN.
//    - flush_cnt_out: accepted flush_in pulses.
//    - Both saturate at all-ones and reset to 0.
//  - Undefined: ports and logic absent; core behaviour identical.
// STRUCTURE
//  - cpu_structs_pkg: typedef enum logic [1:0] {PC_RUN,PC_FLUSH,PC_DRAIN,PC_HALTED} pipe_ctrl_state_e.
//  - cpu_params_pkg: NUM_STG default constant and FLUSH_CYC default constant.
//  - Sub-module pipe_ctrl_perf (saturating counter pair), instantiated only under PIPE_CTRL_PERF_EN.
// TESTING
//  1. Streaming: src_vld=1, dst_rdy=1, no stalls, NUM_STG=5.
//     -> first dst_vld_out on cycle 5 after the first wr_out[0]; one item/cycle thereafter; vld_out=5'b11111.
//  2. Backpressure: fill pipe, dst_rdy=0 for 3 cycles.
//     -> src_rdy_out=0, all strobes 0, occ held; dst_rdy=1 -> all regs advance in the same cycle.
//  3. Mid-stall: stall_in[2]=1 with full pipe.
//     -> rd_out[3:4] continue, reg 3 empties; regs 0..2 frozen; release -> resumes without loss or duplication.
//  4. Flush: full pipe, flush_in=1, idx=2.
//     -> kill_out=5'b00111; next cycle vld_out=5'b11000 minus retired entries.
//     -> src_rdy_out=0 for FLUSH_CYC=2 cycles, then 1.
//  5. Halt: halt_in=1 with 3 items in flight, dst_rdy=1.
//     -> no wr_out[0]; halted_out=1 after last retire; halt_in=0 -> RUN, src_rdy_out=1.
//  6. Reset mid-flush and (PERF_EN) 4 flushes.
//     -> reset: all outputs 0 next cycle, occ=0, RUN.
//     -> PERF_EN: flush_cnt_out=4; stall_cnt_out saturates when preloaded near max.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : pipe_ctrl_pkg
// Brief   : Shared types and default constants for the pipeline sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

    localparam int NUM_STG_DEF   = 5;
    localparam int FLUSH_CYC_DEF = 2;
    localparam int CNT_W_DEF     = 32;

    typedef enum logic [1:0] {
        PC_RUN    = 2'd0,
        PC_FLUSH  = 2'd1,
        PC_DRAIN  = 2'd2,
        PC_HALTED = 2'd3
    } pipe_ctrl_state_e;

    // Registers at or below the flush index are the younger ones to discard.
    function automatic logic in_kill_range(input int stg, input int idx);
        return (stg <= idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : pipe_ctrl_if
// Brief   : Handshake/strobe bundle between pipe_ctrl and the stage registers.
//           PIPE_CTRL_PERF_EN adds the performance counter outputs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STG = NUM_STG_DEF
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNT_W   = CNT_W_DEF
`endif
);

    localparam int IDX_W = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;

    logic               src_vld_in;
    logic               src_rdy_out;
    logic [NUM_STG-1:0] stall_in;
    logic               dst_rdy_in;
    logic               dst_vld_out;
    logic               flush_in;
    logic [IDX_W-1:0]   flush_idx_in;
    logic               halt_in;
    logic               halted_out;
    logic [NUM_STG-1:0] wr_out;
    logic [NUM_STG-1:0] rd_out;
    logic [NUM_STG-1:0] kill_out;
    logic [NUM_STG-1:0] vld_out;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0]   stall_cnt_out;
    logic [CNT_W-1:0]   flush_cnt_out;
`endif

`ifdef PIPE_CTRL_PERF_EN
    modport slave (
        input  src_vld_in, stall_in, dst_rdy_in, flush_in, flush_idx_in, halt_in,
        output src_rdy_out, dst_vld_out, halted_out, wr_out, rd_out, kill_out, vld_out,
        output stall_cnt_out, flush_cnt_out
    );
    modport master (
        output src_vld_in, stall_in, dst_rdy_in, flush_in, flush_idx_in, halt_in,
        input  src_rdy_out, dst_vld_out, halted_out, wr_out, rd_out, kill_out, vld_out,
        input  stall_cnt_out, flush_cnt_out
    );
`else
    modport slave (
        input  src_vld_in, stall_in, dst_rdy_in, flush_in, flush_idx_in, halt_in,
        output src_rdy_out, dst_vld_out, halted_out, wr_out, rd_out, kill_out, vld_out
    );
    modport master (
        output src_vld_in, stall_in, dst_rdy_in, flush_in, flush_idx_in, halt_in,
        input  src_rdy_out, dst_vld_out, halted_out, wr_out, rd_out, kill_out, vld_out
    );
`endif

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_perf.sv
//------------------------------------------------------------------------------
// Module  : pipe_ctrl_perf
// Brief   : Saturating stall/flush event counter pair; present only when
//           PIPE_CTRL_PERF_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk_in,
    input  wire logic             reset_in,
    input  wire logic             i_stall_evt,
    input  wire logic             i_flush_evt,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (i_flush_evt && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule
`endif

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//------------------------------------------------------------------------------
// Module  : pipe_ctrl
// Brief   : Occupancy/handshake sequencer for a chain of single-entry stage
//           registers with flush kill and halt drain. PIPE_CTRL_PERF_EN adds
//           saturating stall/flush counters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STG   = NUM_STG_DEF,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNT_W     = CNT_W_DEF
`endif
) (
    input  wire logic    clk_in,
    input  wire logic    reset_in,
    pipe_ctrl_if.slave   pc_bus
);

    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYC - 1);

    pipe_ctrl_state_e   r_state;
    pipe_ctrl_state_e   w_state_nxt;
    logic [3:0]         r_fcnt;
    logic [3:0]         w_fcnt_nxt;
    logic [NUM_STG-1:0] r_occ;
    logic [NUM_STG-1:0] w_occ_nxt;

    logic [NUM_STG-1:0] w_ksel;
    logic [NUM_STG-1:0] w_adv;
    logic [NUM_STG-1:0] w_wr;
    logic [NUM_STG-1:0] w_kill;
    logic               w_acc0;
    logic               w_run;
    logic               w_src_rdy;
    logic               w_live;

    // Accept ripples from the retire end back toward fetch in one cycle.
    always_comb begin : c_ripple
        logic w_down;
        w_ksel = '0;
        w_adv  = '0;
        w_down = pc_bus.dst_rdy_in;
        for (int i = NUM_STG - 1; i >= 0; i--) begin
            w_ksel[i] = pc_bus.flush_in & in_kill_range(i, int'(pc_bus.flush_idx_in));
            w_adv[i]  = r_occ[i] & ~pc_bus.stall_in[i] & w_down & ~w_ksel[i];
            w_down    = ~r_occ[i] | w_adv[i];
        end
        w_acc0 = w_down;
    end

    assign w_run     = (r_state == PC_RUN);
    assign w_src_rdy = w_acc0 & w_run & ~pc_bus.flush_in & ~pc_bus.halt_in;
    assign w_wr      = {w_adv[NUM_STG-2:0], w_src_rdy & pc_bus.src_vld_in};
    assign w_kill    = r_occ & w_ksel;
    assign w_occ_nxt = w_wr | (r_occ & ~w_adv & ~w_kill);

    always_comb begin : c_fsm
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            PC_RUN: begin
                if (pc_bus.flush_in) begin
                    w_state_nxt = PC_FLUSH;
                    w_fcnt_nxt  = c_FLUSH_LOAD;
                end else if (pc_bus.halt_in) begin
                    w_state_nxt = PC_DRAIN;
                end
            end
            PC_FLUSH: begin
                if (pc_bus.flush_in) begin
                    w_fcnt_nxt = c_FLUSH_LOAD;
                end else if (r_fcnt == 4'd0) begin
                    w_state_nxt = pc_bus.halt_in ? PC_DRAIN : PC_RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt - 4'd1;
                end
            end
            PC_DRAIN: begin
                // A flush while draining only kills; quiesce is judged next cycle.
                if (!pc_bus.flush_in && (w_occ_nxt == '0)) begin
                    w_state_nxt = PC_HALTED;
                end
            end
            PC_HALTED: begin
                if (!pc_bus.halt_in) begin
                    w_state_nxt = PC_RUN;
                end
            end
            default: begin
                w_state_nxt = PC_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= PC_RUN;
            r_fcnt  <= 4'd0;
            r_occ   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    // Every output is held low for the whole time reset is asserted.
    assign w_live = ~reset_in;

    assign pc_bus.src_rdy_out = w_src_rdy & w_live;
    assign pc_bus.dst_vld_out = r_occ[NUM_STG-1] & ~pc_bus.stall_in[NUM_STG-1] & w_live;
    assign pc_bus.halted_out  = (r_state == PC_HALTED) & w_live;
    assign pc_bus.wr_out      = w_wr   & {NUM_STG{w_live}};
    assign pc_bus.rd_out      = w_adv  & {NUM_STG{w_live}};
    assign pc_bus.kill_out    = w_kill & {NUM_STG{w_live}};
    assign pc_bus.vld_out     = r_occ  & {NUM_STG{w_live}};

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .i_stall_evt (pc_bus.src_vld_in & ~w_src_rdy & w_run & w_live),
        .i_flush_evt (pc_bus.flush_in & w_live),
        .o_stall_cnt (pc_bus.stall_cnt_out),
        .o_flush_cnt (pc_bus.flush_cnt_out)
    );
`endif

endmodule

`default_nettype wire
